// File: rtl/fft_pkg.sv
// fft_pkg: shared types, constants and complex helpers for the 8-point FFT datapath.
package fft_pkg;
   localparam int DATA_WIDTH = 50;
   localparam int COEF = 36;
   localparam int DW = DATA_WIDTH / 2;
   localparam int CW = COEF / 2;
   localparam int N_POINTS = 8;
   localparam int HALF = N_POINTS / 2;
   localparam int TWID_FRAC = 16;
   localparam string TWID_FILE = "coef_data.mem";
   typedef struct packed {
      logic signed [DW-1:0] re;
      logic signed [DW-1:0] im;
   } cplx_t;
   typedef struct packed {
      logic signed [CW-1:0] re;
      logic signed [CW-1:0] im;
   } twid_t;
   typedef struct packed {
      logic signed [DW:0] re;
      logic signed [DW:0] im;
   } cwide_t;
   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
   // W^k = e^(-j2pi k/8) in Q2.16, identical to the contents of TWID_FILE
   localparam twid_t TWID [HALF] = '{
      '{18'sd65536, 18'sd0},
      '{18'sd46341, -18'sd46341},
      '{18'sd0, -18'sd65536},
      '{-18'sd46341, -18'sd46341}
   };
   function automatic cwide_t cplx_add(cplx_t x, cplx_t y);
      return '{(DW+1)'(x.re) + (DW+1)'(y.re), (DW+1)'(x.im) + (DW+1)'(y.im)};
   endfunction
   function automatic cwide_t cplx_sub(cplx_t x, cplx_t y);
      return '{(DW+1)'(x.re) - (DW+1)'(y.re), (DW+1)'(x.im) - (DW+1)'(y.im)};
   endfunction
endpackage

// File: rtl/cmul_conj_pipe.sv
// cmul_conj_pipe: two-stage registered t = b * conj(w), products floor-truncated by TWID_FRAC.
module cmul_conj_pipe
   import fft_pkg::*;
(
   input  logic  clk_i,
   input  logic  rst_ni,
   input  cplx_t b,
   input  twid_t w,
   output cplx_t t
);
   logic signed [DW+CW-1:0] p_rr, p_ii, p_ir, p_ri;
   // sums wrap at 43 bits; only bits [40:16] survive so the lost carry is harmless
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         p_rr <= '0;
         p_ii <= '0;
         p_ir <= '0;
         p_ri <= '0;
         t    <= '0;
      end else begin
         p_rr <= (DW+CW)'(b.re) * (DW+CW)'(w.re);
         p_ii <= (DW+CW)'(b.im) * (DW+CW)'(w.im);
         p_ir <= (DW+CW)'(b.im) * (DW+CW)'(w.re);
         p_ri <= (DW+CW)'(b.re) * (DW+CW)'(w.im);
         t.re <= DW'((p_rr + p_ii) >>> TWID_FRAC);
         t.im <= DW'((p_ir - p_ri) >>> TWID_FRAC);
      end
   end
endmodule

// File: rtl/butterfly_inv_dit.sv
// butterfly_inv_dit: inverse radix-2 DIT butterfly stage, one 8-sample frame per handshake.
// Pairs k=0..3 share a 4-stage pipeline: S1 fetch, S2/S3 conj-multiply, S4 add/sub and write.
module butterfly_inv_dit
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = fft_pkg::DATA_WIDTH,
   parameter int COEF       = fft_pkg::COEF,
   parameter int SCALE      = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [DATA_WIDTH-1:0] in_data_i [0:N_POINTS-1],
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   output logic [DATA_WIDTH-1:0] out_data_o [0:N_POINTS-1],
   output logic                  out_valid_o,
   input  logic                  out_ready_i
);
   state_t state, state_nx;
   cplx_t frame [N_POINTS];
   cplx_t a1, b1, a2, a3, t3;
   logic [COEF-1:0] w1;
   logic [2:0] cnt;
   logic [1:0] k1, k2, k3;
   logic v1, v2, v3, issue, done;
   function automatic cplx_t shr(cwide_t s);
      return '{DW'(s.re >>> SCALE), DW'(s.im >>> SCALE)};
   endfunction
   assign issue = (state == RUN) && !cnt[2];
   assign done = v3 && (k3 == 2'd3);
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = state == IDLE ? (in_valid_i ? RUN : IDLE) :
                 state == RUN  ? (done ? HOLD : RUN) :
                                 (out_ready_i ? IDLE : HOLD);
   end
   always_comb begin
      in_ready_o  = state == IDLE;
      out_valid_o = state == HOLD;
   end
   cmul_conj_pipe u_cmul (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .b      (b1),
      .w      (twid_t'(w1)),
      .t      (t3)
   );
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < N_POINTS; i++) begin
            frame[i]      <= '0;
            out_data_o[i] <= '0;
         end
         cnt <= '0;
         {v1, v2, v3} <= '0;
         {k1, k2, k3} <= '0;
         {a1, b1, a2, a3} <= '0;
         w1 <= '0;
      end else begin
         if (state == IDLE && in_valid_i) begin
            for (int i = 0; i < N_POINTS; i++) frame[i] <= cplx_t'(in_data_i[i]);
            cnt <= '0;
         end else if (issue) begin
            cnt <= cnt + 3'd1;
         end
         v1 <= issue;
         k1 <= cnt[1:0];
         a1 <= frame[{1'b0, cnt[1:0]}];
         b1 <= frame[{1'b1, cnt[1:0]}];
         w1 <= TWID[cnt[1:0]];
         {v2, k2, a2} <= {v1, k1, a1};
         {v3, k3, a3} <= {v2, k2, a2};
         if (v3) begin
            out_data_o[{1'b0, k3}] <= shr(cplx_add(a3, t3));
            out_data_o[{1'b1, k3}] <= shr(cplx_sub(a3, t3));
         end
      end
   end
endmodule
